// File: rtl/src_scheduler_pkg.sv
// src_scheduler_pkg: shared defaults and FSM state encoding for the source scheduler
package src_scheduler_pkg;

    localparam int SCHED_N_SRC   = 4;
    localparam int SCHED_TIMEOUT = 1023;

    typedef enum logic [1:0] {
        SCHED_IDLE = 2'd0,
        SCHED_BUSY = 2'd1,
        SCHED_GAP  = 2'd2
    } sched_state_e;

endpackage

// File: rtl/src_scheduler_rr_pick.sv
// src_scheduler_rr_pick: first set request at or after ptr, wrapping from N-1 to 0
module src_scheduler_rr_pick #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          found
);

    // Scan from the farthest offset down so the nearest hit to ptr is written last
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[IW'((int'(ptr) + i) % N)]) idx = IW'((int'(ptr) + i) % N);
        end
        found = |req;
    end

endmodule

// File: rtl/src_scheduler.sv
// src_scheduler: weighted round-robin grant of message sources to the packet encoder
// Optional feature: define SCHED_URGENT_EN to let urgent sources pre-empt the round-robin order.
module src_scheduler
    import src_scheduler_pkg::*;
#(
    parameter  int N_SRC   = SCHED_N_SRC,
    parameter  int W_WGT   = 4,
    parameter  int TIMEOUT = SCHED_TIMEOUT,
    localparam int SW      = $clog2(N_SRC)
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic [N_SRC-1:0]       have_msg_bus,
    input  logic [8*N_SRC-1:0]     len_bus,
    input  logic [N_SRC-1:0]       en_mask,
    input  logic [W_WGT*N_SRC-1:0] weight_bus,
    input  logic [N_SRC-1:0]       urgent_bus,
    input  logic                   pkt_done,
    output logic                   gnt_valid,
    output logic [SW-1:0]          gnt_src,
    output logic [7:0]             gnt_len,
    output logic                   timeout_pulse,
    output logic [SW-1:0]          err_src
);

    localparam int CW = $clog2(TIMEOUT + 1);

    sched_state_e     state_q, state_d;
    logic [SW-1:0]    src_q, src_d;
    logic [7:0]       len_q, len_d;
    logic             tp_q, tp_d;
    logic [SW-1:0]    err_q, err_d;
    logic [SW-1:0]    ptr_q, ptr_d;
    logic [W_WGT-1:0] credit_q, credit_d;
    logic [SW-1:0]    last_q, last_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [N_SRC-1:0] elig;
    logic [SW-1:0]    rr_idx, win;
    logic             any_elig, use_urg, expire;
    logic [W_WGT-1:0] wgt_arr [N_SRC];
    logic [7:0]       len_arr [N_SRC];
    logic [W_WGT-1:0] wgt_m1, new_credit;

    function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] x);
        return (x == SW'(N_SRC - 1)) ? '0 : x + SW'(1);
    endfunction

    for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
        assign wgt_arr[i] = weight_bus[i*W_WGT +: W_WGT];
        assign len_arr[i] = len_bus[i*8 +: 8];
    end

    assign elig = have_msg_bus & en_mask;

    src_scheduler_rr_pick #(.N(N_SRC)) u_rr (
        .req   (elig),
        .ptr   (ptr_q),
        .idx   (rr_idx),
        .found (any_elig)
    );

`ifdef SCHED_URGENT_EN
    logic [N_SRC-1:0] urg_req;
    logic [SW-1:0]    urg_idx, zero_ptr;
    logic             urg_found;

    assign urg_req  = urgent_bus & elig;
    assign zero_ptr = '0;

    src_scheduler_rr_pick #(.N(N_SRC)) u_urg (
        .req   (urg_req),
        .ptr   (zero_ptr),
        .idx   (urg_idx),
        .found (urg_found)
    );

    assign use_urg = urg_found;
    assign win     = urg_found ? urg_idx : rr_idx;
`else
    logic unused_urgent;

    assign unused_urgent = ^urgent_bus;
    assign use_urg       = 1'b0;
    assign win           = rr_idx;
`endif

    assign expire     = (cnt_q == CW'(TIMEOUT - 1));
    assign wgt_m1     = (wgt_arr[rr_idx] == '0) ? '0 : wgt_arr[rr_idx] - W_WGT'(1);
    assign new_credit = ((rr_idx != last_q) || (credit_q == '0)) ? wgt_m1 : credit_q - W_WGT'(1);

    // State and datapath registers, cleared asynchronously so a reset drops any grant silently
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= SCHED_IDLE;
            src_q    <= '0;
            len_q    <= '0;
            tp_q     <= 1'b0;
            err_q    <= '0;
            ptr_q    <= '0;
            credit_q <= '0;
            last_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            len_q    <= len_d;
            tp_q     <= tp_d;
            err_q    <= err_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next state: grant from IDLE, leave BUSY on done or expiry, GAP lasts one cycle
    always_comb begin
        state_d = (state_q == SCHED_IDLE) ? (any_elig ? SCHED_BUSY : SCHED_IDLE)
                : (state_q == SCHED_BUSY) ? ((pkt_done || expire) ? SCHED_GAP : SCHED_BUSY)
                : SCHED_IDLE;
    end

    // Grant capture, weighted credit bookkeeping and the BUSY watchdog; done beats expiry
    always_comb begin
        src_d    = src_q;
        len_d    = len_q;
        err_d    = err_q;
        ptr_d    = ptr_q;
        credit_d = credit_q;
        last_d   = last_q;
        cnt_d    = '0;
        tp_d     = 1'b0;
        if (state_q == SCHED_IDLE && any_elig) begin
            src_d = win;
            len_d = len_arr[win];
            if (!use_urg) begin
                credit_d = new_credit;
                last_d   = rr_idx;
                ptr_d    = (new_credit != '0) ? rr_idx : wrap_inc(rr_idx);
            end
        end else if (state_q == SCHED_BUSY && !pkt_done) begin
            cnt_d = cnt_q + CW'(1);
            if (expire) begin
                cnt_d    = '0;
                tp_d     = 1'b1;
                err_d    = src_q;
                credit_d = '0;
                ptr_d    = wrap_inc(src_q);
            end
        end
    end

    // Outputs come straight from registered state
    always_comb begin
        gnt_valid     = (state_q == SCHED_BUSY);
        gnt_src       = src_q;
        gnt_len       = len_q;
        timeout_pulse = tp_q;
        err_src       = err_q;
    end

endmodule

// File: tb/tb_src_scheduler.sv
// tb_src_scheduler: directed and random checks of src_scheduler against a behavioural model
module tb_src_scheduler;

    localparam int N  = 4;
    localparam int TO = 1023;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [3:0]  have = '0;
    logic [31:0] lens = '0;
    logic [3:0]  en = '0;
    logic [15:0] wgts = 16'h1111;
    logic [3:0]  urg = '0;
    logic        pkt_done = 1'b0;
    logic        gnt_valid, timeout_pulse;
    logic [1:0]  gnt_src, err_src;
    logic [7:0]  gnt_len;

    int n_chk = 0;
    int n_fail = 0;

    src_scheduler #(.N_SRC(N), .W_WGT(4), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .have_msg_bus  (have),
        .len_bus       (lens),
        .en_mask       (en),
        .weight_bus    (wgts),
        .urgent_bus    (urg),
        .pkt_done      (pkt_done),
        .gnt_valid     (gnt_valid),
        .gnt_src       (gnt_src),
        .gnt_len       (gnt_len),
        .timeout_pulse (timeout_pulse),
        .err_src       (err_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: grants are decided from the rules on eligibility, turns per source and the watchdog
    int m_phase, m_age, m_ptr, m_turns, m_last, w_rr, w_urg, wt;
    int e_valid, e_src, e_len, e_tp, e_err;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_phase = 0; m_age = 0; m_ptr = 0; m_turns = 0; m_last = 0;
            e_valid = 0; e_src = 0; e_len = 0; e_tp = 0; e_err = 0;
        end else begin
            e_tp = 0;
            if (m_phase == 1) begin
                m_age++;
                if (pkt_done) begin
                    m_phase = 2; e_valid = 0;
                end else if (m_age == TO) begin
                    m_phase = 2; e_valid = 0; e_tp = 1; e_err = e_src;
                    m_turns = 0; m_ptr = (e_src + 1) % N;
                end
            end else if (m_phase == 2) begin
                m_phase = 0;
            end else begin
                w_rr = -1;
                w_urg = -1;
                for (int k = 0; k < N; k++)
                    if (w_rr < 0 && have[(m_ptr + k) % N] && en[(m_ptr + k) % N]) w_rr = (m_ptr + k) % N;
`ifdef SCHED_URGENT_EN
                for (int k = N - 1; k >= 0; k--)
                    if (urg[k] && have[k] && en[k]) w_urg = k;
`endif
                if (w_rr >= 0) begin
                    m_phase = 1; m_age = 0; e_valid = 1;
                    if (w_urg >= 0) begin
                        e_src = w_urg;
                    end else begin
                        e_src = w_rr;
                        wt = int'(wgts[w_rr*4 +: 4]);
                        if (wt == 0) wt = 1;
                        if (w_rr != m_last || m_turns == 0) m_turns = wt - 1;
                        else m_turns = m_turns - 1;
                        m_last = w_rr;
                        m_ptr = (m_turns > 0) ? w_rr : (w_rr + 1) % N;
                    end
                    e_len = int'(lens[e_src*8 +: 8]);
                end
            end
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        chk("gnt_valid", int'(gnt_valid), e_valid);
        chk("timeout_pulse", int'(timeout_pulse), e_tp);
        chk("err_src", int'(err_src), e_err);
        if (e_valid != 0) begin
            chk("gnt_src", int'(gnt_src), e_src);
            chk("gnt_len", int'(gnt_len), e_len);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        chk("rst_valid", int'(gnt_valid), 0);
        chk("rst_src", int'(gnt_src), 0);
        chk("rst_len", int'(gnt_len), 0);
        chk("rst_tp", int'(timeout_pulse), 0);
        chk("rst_err", int'(err_src), 0);
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic wait_grant(output int s);
        int t = 0;
        while (!gnt_valid && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (!gnt_valid) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_grant: no grant within 64 cycles, got valid=0, expected 1");
        end
        s = int'(gnt_src);
    endtask

    task automatic done_pulse();
        pkt_done = 1'b1;
        @(negedge clk);
        pkt_done = 1'b0;
    endtask

    task automatic run_grants(input int n, input int hold, output int seq[$]);
        int s;
        seq.delete();
        repeat (n) begin
            wait_grant(s);
            seq.push_back(s);
            cyc(hold);
            done_pulse();
        end
    endtask

    task automatic chk_seq(input string nm, input int got[$], input int exp[$]);
        for (int i = 0; i < exp.size(); i++)
            chk(nm, (i < got.size()) ? got[i] : -1, exp[i]);
    endtask

    initial begin
        int seq[$];
        int s;
        int held;
        #200000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
        seq.delete(); s = 0; held = 0;
    end

    initial begin
        int seq[$];
        int s;
        int held;
        lens = {8'd40, 8'd30, 8'd20, 8'd10};
        wgts = 16'h1111;
        have = 4'b1111;
        en   = 4'b1111;
        do_reset();
        @(negedge clk);
        chk("first_grant_latency", int'(gnt_valid), 1);
        chk("first_grant_len", int'(gnt_len), 10);
        begin
            seq.delete();
            repeat (5) begin
                wait_grant(s);
                seq.push_back(s);
                cyc(4);
                done_pulse();
                chk("gap_valid", int'(gnt_valid), 0);
                @(negedge clk);
                chk("idle_valid", int'(gnt_valid), 0);
                @(negedge clk);
            end
        end
        chk_seq("rr_seq", seq, '{0, 1, 2, 3, 0});

        wgts = 16'h1113;
        have = 4'b0011;
        do_reset();
        run_grants(8, 2, seq);
        chk_seq("wrr_seq", seq, '{0, 0, 0, 1, 0, 0, 0, 1});

        wgts = 16'h1111;
        have = 4'b0100;
        do_reset();
        wait_grant(s);
        chk("to_grant_src", s, 2);
        have = 4'b1100;
        held = 1;
        repeat (TO - 1) begin
            @(negedge clk);
            if (!gnt_valid) held = 0;
        end
        chk("to_held", held, 1);
        @(negedge clk);
        chk("to_pulse", int'(timeout_pulse), 1);
        chk("to_err_src", int'(err_src), 2);
        chk("to_valid", int'(gnt_valid), 0);
        @(negedge clk);
        chk("to_pulse_end", int'(timeout_pulse), 0);
        wait_grant(s);
        chk("to_next_src", s, 3);

        cyc(TO - 2);
        pkt_done = 1'b1;
        @(negedge clk);
        pkt_done = 1'b0;
        chk("coinc_pulse", int'(timeout_pulse), 0);
        chk("coinc_valid", int'(gnt_valid), 0);
        chk("coinc_err_src", int'(err_src), 2);

        have = 4'b1111;
        en = 4'b1111;
        do_reset();
        run_grants(1, 1, seq);
        wait_grant(s);
        chk("en_grant_src", s, 1);
        cyc(2);
        en = 4'b1101;
        cyc(5);
        chk("en_held_valid", int'(gnt_valid), 1);
        chk("en_held_src", int'(gnt_src), 1);
        done_pulse();
        run_grants(4, 1, seq);
        chk_seq("en_skip_seq", seq, '{2, 3, 0, 2});
        en = 4'b1111;
        run_grants(3, 1, seq);
        chk_seq("en_back_seq", seq, '{3, 0, 1});

        wait_grant(s);
        cyc(3);
        do_reset();
        @(negedge clk);
        chk("rst_busy_pulse", int'(timeout_pulse), 0);

`ifdef SCHED_URGENT_EN
        have = 4'b0001;
        do_reset();
        run_grants(1, 1, seq);
        have = 4'b1111;
        urg = 4'b1000;
        wait_grant(s);
        chk("urg_src", s, 3);
        urg = 4'b0000;
        cyc(1);
        done_pulse();
        wait_grant(s);
        chk("urg_after_src", s, 1);
        done_pulse();
`endif

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            have = 4'($urandom);
            en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
            lens = $urandom;
            urg = 4'($urandom);
            if ($urandom_range(0, 49) == 0) wgts = 16'($urandom);
            pkt_done = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 699) == 0) begin
                pkt_done = 1'b0;
                do_reset();
            end
        end
        pkt_done = 1'b0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/src_scheduler.md
SRC_SCHEDULER -- requirements
Module: src_scheduler

Interface
REQ-001 Parameter N_SRC, default `N_SRC (4): number of message sources.
REQ-002 Parameter W_WGT, default 4: width of each per-source weight field.
REQ-003 Parameter TIMEOUT, default 1023: maximum cycles a grant is held without pkt_done.
REQ-004 clk  in  1  clock; all logic is rising-edge.
REQ-005 n_rst  in  1  reset, asynchronous, active-low.
REQ-006 have_msg_bus  in  N_SRC  per-source "complete message queued" flag.
REQ-007 len_bus  in  8*N_SRC  per-source message length, bytes.
REQ-008 en_mask  in  N_SRC  per-source enable; 0 makes the source ineligible.
REQ-009 weight_bus  in  W_WGT*N_SRC  packets per round-robin turn; 0 is treated as 1.
REQ-010 urgent_bus  in  N_SRC  urgent request flags; used only with SCHED_URGENT_EN.
REQ-011 pkt_done  in  1  one-cycle pulse from the encoder at the end of the CRC byte.
REQ-012 gnt_valid  out  1  a grant is active.
REQ-013 gnt_src  out  clog2(N_SRC)  index of the granted source; stable while gnt_valid=1.
REQ-014 gnt_len  out  8  length latched at grant time; stable while gnt_valid=1.
REQ-015 timeout_pulse  out  1  one-cycle pulse when a grant is aborted by timeout.
REQ-016 err_src  out  clog2(N_SRC)  source index of the last timeout; holds until the next timeout.

Function
REQ-017 eligible[i] SHALL equal have_msg_bus[i] & en_mask[i].
REQ-018 The FSM SHALL have exactly three states: IDLE, BUSY and GAP.
REQ-019 IDLE: with any source eligible, the next edge SHALL register the winner in gnt_src, register its len in gnt_len, set gnt_valid=1 and enter BUSY, giving 1-cycle latency.
REQ-020 Winner selection SHALL use round-robin: the first eligible index at or after rr_ptr, with wrap-around from N_SRC-1 to 0.
REQ-021 On a grant to source s, if s differs from the previous winner or its credit is 0, credit SHALL load weight(s)-1; otherwise credit SHALL decrement.
REQ-022 rr_ptr SHALL stay at s while credit>0; it SHALL move to (s+1) mod N_SRC when credit reaches 0 or s is no longer eligible in IDLE.
REQ-023 BUSY: the timeout counter SHALL increment every cycle; pkt_done=1 SHALL clear gnt_valid, clear the counter and enter GAP.
REQ-024 BUSY: when the counter reaches TIMEOUT with no pkt_done, the FSM SHALL clear gnt_valid, pulse timeout_pulse, load err_src=gnt_src, force credit=0, advance rr_ptr and enter GAP.
REQ-025 If pkt_done and expiry coincide, pkt_done SHALL take precedence and no timeout SHALL be reported.
REQ-026 GAP SHALL last exactly 1 cycle, then go to IDLE, so the encoder's have_msg/len can settle.
REQ-027 pkt_done outside BUSY SHALL be ignored.
REQ-028 Clearing en_mask or have_msg for the granted source during BUSY SHALL NOT shorten the grant.
REQ-029 gnt_len=0 SHALL be granted normally (header plus CRC only).

Reset
REQ-030 Asserting n_rst SHALL immediately force: state=IDLE, gnt_valid=0, gnt_src=0, gnt_len=0, timeout_pulse=0, err_src=0, rr_ptr=0, credit=0, counter=0.
REQ-031 Reset asserted mid-BUSY SHALL drop the grant with no timeout report.

Configuration
REQ-032 With SCHED_URGENT_EN defined, an IDLE winner SHALL be the lowest-index source with urgent_bus & eligible set, if any such source exists.
REQ-033 An urgent grant SHALL leave rr_ptr and credit unchanged.
REQ-034 Without SCHED_URGENT_EN, urgent_bus SHALL exist but be ignored, and pure weighted round-robin SHALL apply.

Structure
REQ-035 defines.v SHALL hold N_SRC, the state encodings SCHED_IDLE/BUSY/GAP and the default timeout SCHED_TIMEOUT.
REQ-036 One combinational sub-module rr_pick (req vector, ptr -> index, found) SHALL be used; it SHALL be instantiated twice under SCHED_URGENT_EN (round-robin and fixed-priority with ptr=0).

Verification
REQ-037 Reset, all weights=1, have_msg=4'b1111, pkt_done 5 cycles after each grant -> gnt_src sequence 0,1,2,3,0; gnt_valid rises 1 cycle after IDLE entry.
REQ-038 weight_bus={1,1,1,3}, sources 0 and 1 always requesting -> grants 0,0,0,1,0,0,0,1.
REQ-039 Grant to src 2, no pkt_done -> after TIMEOUT=1023 cycles timeout_pulse=1 for 1 cycle, err_src=2, gnt_valid=0, next grant goes to src 3.
REQ-040 pkt_done on the same cycle as counter expiry -> timeout_pulse stays 0, normal GAP.
REQ-041 SCHED_URGENT_EN, rr_ptr=1, urgent_bus=4'b1000, all requesting -> grant 3, then grant 1 (rr_ptr unchanged).
REQ-042 en_mask[1] cleared mid-grant to src 1 -> grant held until pkt_done; src 1 is not granted again until re-enabled.
